// File: rtl/dram_cmd_scheduler_if.sv
// Request and DRAM-command bundle between requesters and the command scheduler.
// The slave side belongs to the scheduler; the master side belongs to the requesters.
interface dram_cmd_scheduler_if #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8
);
    localparam int RW = $clog2(NUM_OF_ROWS);
    localparam int CW = $clog2(NUM_OF_COLS);
    localparam int BW = $clog2(NUM_OF_BANKS);

    logic [NUM_OF_BANKS-1:0]    req_valid;
    logic [NUM_OF_BANKS-1:0]    req_we;
    logic [NUM_OF_BANKS*RW-1:0] req_row;
    logic [NUM_OF_BANKS*CW-1:0] req_col;
    logic [NUM_OF_BANKS-1:0]    req_ack;
    logic [1:0]                 cmd;
    logic                       cmd_we;
    logic [BW-1:0]              cs;
    logic [RW-1:0]              row_addr;
    logic [CW-1:0]              col_addr;
    logic                       rsp_valid;
    logic [BW-1:0]              rsp_id;

    modport master (
        output req_valid, req_we, req_row, req_col,
        input  req_ack, cmd, cmd_we, cs, row_addr, col_addr, rsp_valid, rsp_id
    );

    modport slave (
        input  req_valid, req_we, req_row, req_col,
        output req_ack, cmd, cmd_we, cs, row_addr, col_addr, rsp_valid, rsp_id
    );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Single-outstanding DRAM command scheduler: round-robin requester arbitration,
// open-page row tracking per bank, and PRE/ACT/RDWR sequencing with tRP/tRCD/tCAS waits.
module dram_cmd_scheduler #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RP         = 2,
    parameter int T_RCD        = 2,
    parameter int T_CAS        = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    dram_cmd_scheduler_if.slave  bus
);
    localparam int RW    = $clog2(NUM_OF_ROWS);
    localparam int CW    = $clog2(NUM_OF_COLS);
    localparam int BW    = $clog2(NUM_OF_BANKS);
    localparam int T_MAX = (T_RP > T_RCD) ? ((T_RP > T_CAS) ? T_RP : T_CAS)
                                          : ((T_RCD > T_CAS) ? T_RCD : T_CAS);
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRE      = 3'd1;
    localparam logic [2:0] S_WAIT_RP  = 3'd2;
    localparam logic [2:0] S_ACT      = 3'd3;
    localparam logic [2:0] S_WAIT_RCD = 3'd4;
    localparam logic [2:0] S_RDWR     = 3'd5;
    localparam logic [2:0] S_WAIT_CAS = 3'd6;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_ACT  = 2'b01;
    localparam logic [1:0] CMD_RDWR = 2'b10;
    localparam logic [1:0] CMD_PRE  = 2'b11;

    logic [2:0]                   state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]                ptr_q, ptr_d;
    logic [BW-1:0]                win_q, win_d;
    logic                         we_q, we_d;
    logic [RW-1:0]                row_q, row_d;
    logic [CW-1:0]                col_q, col_d;
    logic [NUM_OF_BANKS-1:0]      open_vld_q, open_vld_d;
    logic [NUM_OF_BANKS-1:0][RW-1:0] open_row_q, open_row_d;

    logic [NUM_OF_BANKS-1:0]      req_ack_q, req_ack_d;
    logic [1:0]                   cmd_q, cmd_d;
    logic                         cmd_we_q, cmd_we_d;
    logic [BW-1:0]                cs_q, cs_d;
    logic [RW-1:0]                row_addr_q, row_addr_d;
    logic [CW-1:0]                col_addr_q, col_addr_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [BW-1:0]                rsp_id_q, rsp_id_d;

    logic                         grant_vld;
    logic [BW-1:0]                grant;

    // Round-robin search: first pending requester at or after the pointer, wrapping.
    always_comb begin
        // NOTE: every combinational output is defaulted before any branch so no latch is inferred.
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_OF_BANKS; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_OF_BANKS;
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = BW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        we_d       = we_q;
        row_d      = row_q;
        col_d      = col_q;
        open_vld_d = open_vld_q;
        open_row_d = open_row_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    win_d = grant;
                    we_d  = bus.req_we[grant];
                    row_d = bus.req_row[int'(grant)*RW +: RW];
                    col_d = bus.req_col[int'(grant)*CW +: CW];
                    if (!open_vld_q[grant])                state_d = S_ACT;
                    else if (open_row_q[grant] == row_d)   state_d = S_RDWR;
                    else                                   state_d = S_PRE;
                end
            end
            S_PRE: begin
                open_vld_d[win_q] = 1'b0;
                cnt_d             = CNT_W'(T_RP - 1);
                state_d           = S_WAIT_RP;
            end
            S_WAIT_RP: begin
                if (cnt_q == '0) state_d = S_ACT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACT: begin
                open_vld_d[win_q] = 1'b1;
                open_row_d[win_q] = row_q;
                cnt_d             = CNT_W'(T_RCD - 1);
                state_d           = S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                if (cnt_q == '0) state_d = S_RDWR;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RDWR: begin
                ptr_d = (win_q == BW'(NUM_OF_BANKS - 1)) ? '0 : win_q + 1'b1;
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CNT_W'(T_CAS - 1);
                    state_d = S_WAIT_CAS;
                end
            end
            S_WAIT_CAS: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up with the state.
    always_comb begin
        cmd_d       = CMD_NOP;
        cmd_we_d    = 1'b0;
        cs_d        = '0;
        row_addr_d  = '0;
        col_addr_d  = '0;
        req_ack_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        unique case (state_d)
            S_PRE: begin
                cmd_d = CMD_PRE;
                cs_d  = win_d;
            end
            S_ACT: begin
                cmd_d      = CMD_ACT;
                cs_d       = win_d;
                row_addr_d = row_d;
            end
            S_RDWR: begin
                cmd_d      = CMD_RDWR;
                cs_d       = win_d;
                cmd_we_d   = we_d;
                col_addr_d = col_d;
                req_ack_d  = NUM_OF_BANKS'(1) << win_d;
            end
            S_WAIT_CAS: begin
                rsp_valid_d = (cnt_d == '0);
                rsp_id_d    = (cnt_d == '0) ? win_d : '0;
            end
            default: ;
        endcase
    end

    // NOTE: the open-row table is tiny, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            win_q       <= '0;
            we_q        <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            open_vld_q  <= '0;
            open_row_q  <= '0;
            req_ack_q   <= '0;
            cmd_q       <= CMD_NOP;
            cmd_we_q    <= 1'b0;
            cs_q        <= '0;
            row_addr_q  <= '0;
            col_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            row_q       <= row_d;
            col_q       <= col_d;
            open_vld_q  <= open_vld_d;
            open_row_q  <= open_row_d;
            req_ack_q   <= req_ack_d;
            cmd_q       <= cmd_d;
            cmd_we_q    <= cmd_we_d;
            cs_q        <= cs_d;
            row_addr_q  <= row_addr_d;
            col_addr_q  <= col_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_we    = cmd_we_q;
    assign bus.cs        = cs_q;
    assign bus.row_addr  = row_addr_q;
    assign bus.col_addr  = col_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed and randomized bench for dram_cmd_scheduler; expected command traces are
// built per transaction from a bank-state/round-robin reference model.
module tb_dram_cmd_scheduler;
    localparam int NB    = 8;
    localparam int NR    = 128;
    localparam int NC    = 8;
    localparam int T_RP  = 2;
    localparam int T_RCD = 2;
    localparam int T_CAS = 2;
    localparam int RW    = $clog2(NR);
    localparam int CW    = $clog2(NC);
    localparam int BW    = $clog2(NB);

    typedef struct packed {
        logic [1:0]    cmd;
        logic          we;
        logic [BW-1:0] cs;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [NB-1:0] ack;
        logic          rsp;
        logic [BW-1:0] rid;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    dram_cmd_scheduler_if #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus ();

    dram_cmd_scheduler #(
        .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
        .T_RP(T_RP), .T_RCD(T_RCD), .T_CAS(T_CAS)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Requester-side view of what each requester is presenting.
    bit rq_valid [NB];
    bit rq_we    [NB];
    int rq_row   [NB];
    int rq_col   [NB];

    // Reference model: which row each bank has open, and the round-robin pointer.
    bit m_open [NB];
    int m_row  [NB];
    int m_ptr;

    obs_t zero_obs;

    task automatic check(input string tag, input obs_t obs, input obs_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t s;
        s = {bus.cmd, bus.cmd_we, bus.cs, bus.row_addr, bus.col_addr,
             bus.req_ack, bus.rsp_valid, bus.rsp_id};
        return s;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NB; i++) begin
            bus.req_valid[i]          = rq_valid[i];
            bus.req_we[i]             = rq_we[i];
            bus.req_row[i*RW +: RW]   = RW'(rq_row[i]);
            bus.req_col[i*CW +: CW]   = CW'(rq_col[i]);
        end
    endtask

    task automatic set_req(input int i, input bit we, input int row, input int col);
        rq_valid[i] = 1'b1;
        rq_we[i]    = we;
        rq_row[i]   = row;
        rq_col[i]   = col;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NB; i++) rq_valid[i] = 1'b0;
        drive_reqs();
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
        end
        m_ptr = 0;
    endfunction

    // Runs one transaction from an IDLE cycle. after_ack: 0 drop valid, 1 keep row with
    // new we/col, 2 fully new random request. abort_after >= 0 pulls reset after that cycle.
    task automatic do_txn(input string tag, input int after_ack, input int abort_after,
                          output int winner);
        obs_t q[$];
        obs_t e;
        int   w;
        bit   we;
        int   row, col;
        w = -1;
        for (int k = 0; k < NB; k++) begin
            int i;
            i = (m_ptr + k) % NB;
            if (w < 0 && rq_valid[i]) w = i;
        end
        winner = w;
        if (w < 0) return;
        we  = rq_we[w];
        row = rq_row[w];
        col = rq_col[w];

        if (!(m_open[w] && m_row[w] == row)) begin
            if (m_open[w]) begin
                e = zero_obs; e.cmd = 2'b11; e.cs = BW'(w); q.push_back(e);
                repeat (T_RP) q.push_back(zero_obs);
            end
            e = zero_obs; e.cmd = 2'b01; e.cs = BW'(w); e.row = RW'(row); q.push_back(e);
            repeat (T_RCD) q.push_back(zero_obs);
        end
        e = zero_obs; e.cmd = 2'b10; e.cs = BW'(w); e.we = we; e.col = CW'(col);
        e.ack = NB'(1) << w;
        q.push_back(e);
        if (!we) begin
            repeat (T_CAS - 1) q.push_back(zero_obs);
            e = zero_obs; e.rsp = 1'b1; e.rid = BW'(w); q.push_back(e);
        end
        q.push_back(zero_obs);

        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk); #1;
            check($sformatf("%s[%0d]", tag, k), sample(), q[k]);
            if (q[k].ack != '0) begin
                if (after_ack == 0) begin
                    rq_valid[w] = 1'b0;
                end else begin
                    rq_we[w]  = 1'($urandom_range(0, 1));
                    rq_col[w] = int'($urandom_range(0, NC - 1));
                    if (after_ack == 2) rq_row[w] = int'($urandom_range(0, 3));
                end
                drive_reqs();
            end
            if (k == abort_after) begin
                rst_b = 1'b0;
                #1;
                check({tag, "_async_rst"}, sample(), zero_obs);
                return;
            end
        end
        m_open[w] = 1'b1;
        m_row[w]  = row;
        m_ptr     = (w + 1) % NB;
    endtask

    task automatic hold_reset_and_release(input string tag);
        model_reset();
        repeat (2) begin
            @(posedge clk); #1;
            check(tag, sample(), zero_obs);
        end
        rst_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        zero_obs = '0;
        for (int i = 0; i < NB; i++) begin
            rq_valid[i] = 1'b0; rq_we[i] = 1'b0; rq_row[i] = 0; rq_col[i] = 0;
        end
        drive_reqs();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", sample(), zero_obs);
        rst_b = 1'b1;

        // Closed bank read, then row hit, then row miss write
        set_req(2, 1'b0, 5, 3); drive_reqs();
        do_txn("closed_rd", 0, -1, w);
        check_int("closed_rd_winner", w, 2);
        set_req(2, 1'b0, 5, 3); drive_reqs();
        do_txn("hit_rd", 0, -1, w);
        set_req(2, 1'b1, 9, 6); drive_reqs();
        do_txn("miss_wr", 0, -1, w);

        // Bring pointer to 0, then all requesters held: order 0..7 then wrap to 0
        set_req(7, 1'b0, 1, 1); drive_reqs();
        do_txn("ptr_to0", 0, -1, w);
        for (int i = 0; i < NB; i++) set_req(i, i[0], (i == 2) ? 9 : 20 + i, i);
        drive_reqs();
        for (int k = 0; k < 2 * NB + 1; k++) begin
            do_txn($sformatf("rr%0d", k), 1, -1, w);
            check_int($sformatf("rr_order%0d", k), w, k % NB);
        end
        clear_reqs();

        // Pointer at 6 with requesters 0 and 1 pending
        set_req(5, 1'b1, 25, 2); drive_reqs();
        do_txn("ptr_to6", 0, -1, w);
        set_req(0, 1'b0, 20, 4); set_req(1, 1'b1, 21, 5); drive_reqs();
        do_txn("p6_first", 0, -1, w);
        check_int("p6_first_winner", w, 0);
        do_txn("p6_second", 0, -1, w);
        check_int("p6_second_winner", w, 1);

        // Randomized traffic with small row range to mix hits, misses and closed banks
        for (int t = 0; t < 60; t++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NB; i++) begin
                if (!rq_valid[i] && $urandom_range(0, 3) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, NC - 1)));
                any |= rq_valid[i];
            end
            if (!any)
                set_req(int'($urandom_range(0, NB - 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, NC - 1)));
            drive_reqs();
            do_txn($sformatf("rnd%0d", t), int'($urandom_range(0, 2)), -1, w);
        end
        clear_reqs();

        // Reset mid-sequence: during WAIT_RCD of a miss, then during an ACT cycle
        rst_b = 1'b0; #1;
        check("rst_idle", sample(), zero_obs);
        hold_reset_and_release("rst_idle_hold");
        set_req(4, 1'b0, 7, 1); drive_reqs();
        do_txn("pre_abort", 0, -1, w);
        set_req(4, 1'b0, 8, 2); drive_reqs();
        do_txn("abort_rcd", 0, T_RP + 2, w);
        hold_reset_and_release("abort_rcd_hold");
        do_txn("retry_rcd", 0, -1, w);
        check_int("retry_rcd_winner", w, 4);
        set_req(6, 1'b1, 3, 7); drive_reqs();
        do_txn("abort_act", 0, 0, w);
        hold_reset_and_release("abort_act_hold");
        do_txn("retry_act", 0, -1, w);
        check_int("retry_act_winner", w, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
